inst_pos_responder: RTL and testbench

- Responder for the posedge instruction channel, the multi-cycle side of the instruction demux.
- Accepts a level request with a word address and fetches the word from a backing memory port (req/gnt then rvalid).
- Returns a one-cycle ack together with data and error.
- Holds a one-entry last-word buffer so repeated fetches of the same word complete without a memory access.
- Flags misaligned, out-of-window and timed-out fetches as errors.

---
 rtl/inst_pos_responder.sv | 142 ++++++++++++++
 tb/tb_inst_pos_responder.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_pos_responder.sv
// Multi-cycle posedge instruction fetch responder with a one-entry last-word buffer.
// Latency: hit or error 2 cycles, miss 4 cycles minimum; the initiator holds req until ack.
module inst_pos_responder #(
    parameter logic [31:0] WIN_BASE = 32'h0,
    parameter logic [31:0] WIN_END  = 32'h0fff,
    parameter int unsigned TIMEOUT  = 64,
    parameter bit          BUF_EN   = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        inst_req_i,
    input  logic [31:0] inst_addr_i,
    output logic        inst_ack_o,
    output logic [31:0] inst_data_o,
    output logic        inst_error_o,
    input  logic        flush_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_err_i
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    logic [1:0]  state_q;
    logic [29:0] addr_q;
    logic [7:0]  cnt_q;
    logic        drain_pend_q;
    logic        buf_vld_q;
    logic [29:0] buf_addr_q;
    logic [31:0] buf_dat_q;
    logic        ack_q;
    logic [31:0] data_q;
    logic        err_q;

    logic below_win;
    logic above_win;
    logic addr_bad;
    logic buf_hit;
    logic tmo;

    // Window bounds are compared by the sign of a 21-bit difference on the 4KB page number.
    always_comb begin
        below_win = 1'(({1'b0, inst_addr_i[31:12]} - {1'b0, WIN_BASE[31:12]}) >> 20);
        above_win = 1'(({1'b0, WIN_END[31:12]} - {1'b0, inst_addr_i[31:12]}) >> 20);
        addr_bad  = (inst_addr_i[1:0] != 2'b00) || below_win || above_win;
        buf_hit   = BUF_EN && buf_vld_q && (buf_addr_q == inst_addr_i[31:2]) && !flush_i;
        tmo       = (cnt_q >= TMO_LAST);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            cnt_q        <= '0;
            drain_pend_q <= 1'b0;
            buf_vld_q    <= 1'b0;
            buf_addr_q   <= '0;
            buf_dat_q    <= '0;
            ack_q        <= 1'b0;
            data_q       <= '0;
            err_q        <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            // A response orphaned by an earlier timeout is swallowed here.
            if (drain_pend_q && mem_rvalid_i) begin
                drain_pend_q <= 1'b0;
            end
            if ((state_q == S_REQ || state_q == S_WAIT) && cnt_q != 8'hff) begin
                cnt_q <= cnt_q + 8'd1;
            end
            case (state_q)
                S_IDLE: begin
                    // ack_q high means this req is the one just answered.
                    if (inst_req_i && !ack_q) begin
                        addr_q <= inst_addr_i[31:2];
                        if (addr_bad) begin
                            state_q <= S_RESP;
                            data_q  <= '0;
                            err_q   <= 1'b1;
                        end else if (buf_hit) begin
                            state_q <= S_RESP;
                            data_q  <= buf_dat_q;
                            err_q   <= 1'b0;
                        end else if (!drain_pend_q) begin
                            state_q <= S_REQ;
                            cnt_q   <= '0;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_gnt_i) begin
                        state_q <= S_WAIT;
                    end else if (tmo) begin
                        state_q <= S_RESP;
                        data_q  <= '0;
                        err_q   <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (mem_rvalid_i) begin
                        state_q <= S_RESP;
                        data_q  <= mem_rdata_i;
                        err_q   <= mem_err_i;
                        if (!mem_err_i && BUF_EN) begin
                            buf_vld_q  <= 1'b1;
                            buf_addr_q <= addr_q;
                            buf_dat_q  <= mem_rdata_i;
                        end
                    end else if (tmo) begin
                        state_q      <= S_RESP;
                        data_q       <= '0;
                        err_q        <= 1'b1;
                        drain_pend_q <= 1'b1;
                    end
                end
                default: begin
                    ack_q   <= inst_req_i;
                    state_q <= S_IDLE;
                end
            endcase
            // Flush overrides a fill landing on the same edge.
            if (flush_i) begin
                buf_vld_q <= 1'b0;
            end
        end
    end

    assign mem_req_o    = (state_q == S_REQ);
    assign mem_addr_o   = {addr_q, 2'b00};
    assign inst_ack_o   = ack_q;
    assign inst_data_o  = data_q;
    assign inst_error_o = err_q;

endmodule

// File: tb/tb_inst_pos_responder.sv
// Directed bench for inst_pos_responder: a transaction-level model predicts each fetch's
// ack cycle, data, error and memory-request window; a per-cycle process compares against it.
module tb_inst_pos_responder;

    localparam int          TMO = 8;
    localparam logic [31:0] WB  = 32'h0;
    localparam logic [31:0] WE  = 32'h0fff;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        inst_req_i = 1'b0;
    logic [31:0] inst_addr_i = '0;
    logic        inst_ack_o;
    logic [31:0] inst_data_o;
    logic        inst_error_o;
    logic        flush_i = 1'b0;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i = 1'b0;
    logic        mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;
    logic        mem_err_i = 1'b0;

    inst_pos_responder #(
        .WIN_BASE(WB),
        .WIN_END (WE),
        .TIMEOUT (TMO),
        .BUF_EN  (1'b1)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .inst_req_i  (inst_req_i),
        .inst_addr_i (inst_addr_i),
        .inst_ack_o  (inst_ack_o),
        .inst_data_o (inst_data_o),
        .inst_error_o(inst_error_o),
        .flush_i     (flush_i),
        .mem_req_o   (mem_req_o),
        .mem_addr_o  (mem_addr_o),
        .mem_gnt_i   (mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i (mem_rdata_i),
        .mem_err_i   (mem_err_i)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Expectations for the fetch in flight, in absolute cycle numbers.
    int          exp_ack = -1;
    int          m_from  = -1;
    int          m_to    = -2;
    logic [31:0] exp_data = '0;
    logic        exp_err = 1'b0;
    logic [31:0] exp_maddr = '0;

    // Abstract buffer and drain state.
    bit          m_vld = 1'b0;
    bit          m_drain = 1'b0;
    logic [29:0] m_addr = '0;
    logic [31:0] m_dat = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk_i) begin
        if (chk_en) begin
            chk("ack", {31'b0, inst_ack_o}, {31'b0, cyc == exp_ack});
            if (cyc == exp_ack) begin
                chk("ack_data", inst_data_o, exp_data);
                chk("ack_err", {31'b0, inst_error_o}, {31'b0, exp_err});
            end
            chk("mem_req", {31'b0, mem_req_o}, {31'b0, (cyc >= m_from) && (cyc <= m_to)});
            if (mem_req_o) chk("mem_addr", mem_addr_o, exp_maddr);
        end
    end

    // g: REQ cycles before gnt (>=TMO: never); r: cycles gnt->rvalid; fl/drop_at/drain_rv: cycle offsets or -1.
    task automatic fetch(input logic [31:0] a, input int g, input int r, input logic [31:0] rd,
                         input logic me, input int drop_at, input int fl, input int drain_rv,
                         input logic [31:0] drain_rd,
                         output int obs_lat, output logic [31:0] obs_data, output logic obs_err);
        int s, gc, rc, resp, ackc, last, fillc, c0, mf, mt, page;
        bit bad, hit, to_wait;
        logic [31:0] ed;
        logic ee;
        page = int'(a >> 12);
        bad  = (a[1:0] != 2'b00) || (page < int'(WB >> 12)) || (page > int'(WE >> 12));
        hit  = !bad && m_vld && (m_addr == a[31:2]) && (fl != 0);
        gc = -1; rc = -1; fillc = -1; to_wait = 1'b0; mf = -1; mt = -2; s = 1;
        if (bad) begin
            resp = 1; ed = '0; ee = 1'b1;
        end else if (hit) begin
            resp = 1; ed = m_dat; ee = 1'b0;
        end else begin
            s  = m_drain ? drain_rv + 2 : 1;
            mf = s;
            if (g >= TMO) begin
                mt = s + TMO - 1; resp = s + TMO; ed = '0; ee = 1'b1;
            end else begin
                gc = s + g; mt = gc;
                if (g + r >= TMO) begin
                    resp = s + TMO; ed = '0; ee = 1'b1; to_wait = 1'b1;
                end else begin
                    rc = gc + r; resp = rc + 1; ed = rd; ee = me;
                    if (!me) fillc = rc;
                end
            end
        end
        ackc = (drop_at >= 0 && drop_at <= resp) ? -1 : resp + 1;
        last = ((ackc >= 0) ? ackc : resp) + 1;

        @(posedge clk_i); #1;
        c0        = cyc;
        exp_ack   = (ackc >= 0) ? c0 + ackc : -1;
        exp_data  = ed;
        exp_err   = ee;
        exp_maddr = {a[31:2], 2'b00};
        m_from    = (mf >= 0) ? c0 + mf : -1;
        m_to      = (mf >= 0) ? c0 + mt : -2;
        obs_lat = -1; obs_data = '0; obs_err = 1'b0;
        for (int i = 0; i <= last; i++) begin
            if (i > 0) begin
                @(posedge clk_i); #1;
            end
            inst_req_i   = (drop_at < 0 || i < drop_at) && (i < last);
            inst_addr_i  = a;
            mem_gnt_i    = (i == gc);
            mem_rvalid_i = (i == rc) || (i == drain_rv);
            mem_rdata_i  = (i == drain_rv) ? drain_rd : rd;
            mem_err_i    = (i == rc) && me;
            flush_i      = (i == fl);
            if (inst_ack_o && obs_lat < 0) begin
                obs_lat = i; obs_data = inst_data_o; obs_err = inst_error_o;
            end
        end

        if (m_drain && drain_rv >= 0) m_drain = 1'b0;
        if (to_wait) m_drain = 1'b1;
        if (fillc >= 0) begin
            m_vld = (fl < fillc); m_addr = a[31:2]; m_dat = rd;
        end else if (fl >= 0) begin
            m_vld = 1'b0;
        end
    endtask

    int          lat;
    logic [31:0] d;
    logic        e;

    initial begin
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_ack", {31'b0, inst_ack_o}, 32'd0);
        chk("rst_data", inst_data_o, 32'd0);
        chk("rst_err", {31'b0, inst_error_o}, 32'd0);
        chk("rst_mreq", {31'b0, mem_req_o}, 32'd0);
        chk("rst_maddr", mem_addr_o, 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        chk_en = 1'b1;

        fetch(32'h0000_0100, 0, 1, 32'hDEAD_BEEF, 1'b0, -1, -1, -1, 0, lat, d, e);
        chk("miss_lat", lat, 32'd4);
        chk("miss_data", d, 32'hDEAD_BEEF);
        chk("miss_err", {31'b0, e}, 32'd0);
        fetch(32'h0000_0100, 0, 1, 32'h0BAD_0BAD, 1'b0, -1, -1, -1, 0, lat, d, e);
        chk("hit_lat", lat, 32'd2);
        chk("hit_data", d, 32'hDEAD_BEEF);

        fetch(32'h0000_0102, 0, 1, 32'h1111_1111, 1'b0, -1, -1, -1, 0, lat, d, e);
        chk("misalign_lat", lat, 32'd2);
        chk("misalign_err", {31'b0, e}, 32'd1);
        chk("misalign_data", d, 32'd0);
        fetch(32'h0000_1000, 0, 1, 32'h1111_1111, 1'b0, -1, -1, -1, 0, lat, d, e);
        chk("window_lat", lat, 32'd2);
        chk("window_err", {31'b0, e}, 32'd1);

        fetch(32'h0000_0400, 255, 1, 32'h0, 1'b0, -1, -1, -1, 0, lat, d, e);
        chk("stall_lat", lat, 32'd10);
        chk("stall_err", {31'b0, e}, 32'd1);
        fetch(32'h0000_0400, 0, 1, 32'h0000_0044, 1'b0, -1, -1, -1, 0, lat, d, e);
        chk("post_stall_lat", lat, 32'd4);
        chk("post_stall_data", d, 32'h0000_0044);

        fetch(32'h0000_0300, 0, 100, 32'h0, 1'b0, -1, -1, -1, 0, lat, d, e);
        chk("wait_tmo_lat", lat, 32'd10);
        chk("wait_tmo_err", {31'b0, e}, 32'd1);
        fetch(32'h0000_0300, 0, 1, 32'hCAFE_F00D, 1'b0, -1, -1, 3, 32'h1234_5678, lat, d, e);
        chk("drain_lat", lat, 32'd8);
        chk("drain_data", d, 32'hCAFE_F00D);
        fetch(32'h0000_0300, 0, 1, 32'h1234_5678, 1'b0, -1, -1, -1, 0, lat, d, e);
        chk("drain_hit_data", d, 32'hCAFE_F00D);

        fetch(32'h0000_0200, 1, 2, 32'h2222_0000, 1'b0, -1, 4, -1, 0, lat, d, e);
        chk("flush_fill_lat", lat, 32'd6);
        chk("flush_fill_data", d, 32'h2222_0000);
        fetch(32'h0000_0200, 0, 1, 32'h2222_0001, 1'b0, -1, -1, -1, 0, lat, d, e);
        chk("after_flush_lat", lat, 32'd4);
        fetch(32'h0000_0200, 0, 1, 32'h2222_0002, 1'b0, -1, 0, -1, 0, lat, d, e);
        chk("flush_decode_lat", lat, 32'd4);
        chk("flush_decode_data", d, 32'h2222_0002);

        fetch(32'h0000_0600, 0, 3, 32'h0000_6666, 1'b0, 3, -1, -1, 0, lat, d, e);
        chk("drop_noack", lat, 32'hffff_ffff);
        fetch(32'h0000_0600, 0, 1, 32'h0, 1'b0, -1, -1, -1, 0, lat, d, e);
        chk("drop_hit_lat", lat, 32'd2);
        chk("drop_hit_data", d, 32'h0000_6666);

        fetch(32'h0000_0700, 0, 1, 32'h0000_7777, 1'b1, -1, -1, -1, 0, lat, d, e);
        chk("merr_err", {31'b0, e}, 32'd1);
        fetch(32'h0000_0700, 0, 1, 32'h0000_7778, 1'b0, -1, -1, -1, 0, lat, d, e);
        chk("merr_nobuf_lat", lat, 32'd4);

        // Reset asserted mid-cycle while the request is outstanding.
        chk_en = 1'b0;
        exp_ack = -1; m_from = -1; m_to = -2;
        @(posedge clk_i); #1;
        inst_req_i = 1'b1; inst_addr_i = 32'h0000_0500;
        repeat (3) @(posedge clk_i);
        #1;
        chk("pre_rst_mreq", {31'b0, mem_req_o}, 32'd1);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("mid_rst_mreq", {31'b0, mem_req_o}, 32'd0);
        chk("mid_rst_ack", {31'b0, inst_ack_o}, 32'd0);
        chk("mid_rst_data", inst_data_o, 32'd0);
        inst_req_i = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        m_vld = 1'b0; m_drain = 1'b0;
        chk_en = 1'b1;
        fetch(32'h0000_0100, 0, 1, 32'h5555_AAAA, 1'b0, -1, -1, -1, 0, lat, d, e);
        chk("post_rst_miss_lat", lat, 32'd4);
        chk("post_rst_miss_data", d, 32'h5555_AAAA);

        repeat (2) @(posedge clk_i);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
